// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_e;

  typedef enum logic [1:0] {ROW_NONE, ROW_SINGLE, ROW_MULTI} row_class_e;

  typedef struct packed {
    row_class_e cls;
    logic [1:0] idx;
  } row_info_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Classifies an active-low 4-bit vector; idx is meaningful only for ROW_SINGLE.
  function automatic row_info_t row_onehot_idx(input logic [3:0] row);
    row_info_t   info;
    int unsigned zeros;
    info.cls = ROW_NONE;
    info.idx = '0;
    zeros    = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!row[i]) begin
        zeros++;
        info.idx = 2'(i);
      end
    end
    if (zeros == 1)
      info.cls = ROW_SINGLE;
    else if (zeros > 1)
      info.cls = ROW_MULTI;
    return info;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer with a parameterised asynchronous reset value.
module sync_2ff #(
  parameter int unsigned          WIDTH   = 1,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobing, debounced press/release, one valid pulse per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 65000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned        CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned        MATCH_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(SCAN_DIV - 1);
  localparam logic [MATCH_W-1:0] MATCH_DONE = MATCH_W'(DEBOUNCE_SCANS);
  localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);

  logic [3:0]         row_s;
  row_info_t          row_info;
  logic               tick;
  logic [3:0]         col_rot;
  logic [1:0]         col_idx;
  logic [MATCH_W-1:0] match_inc;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [3:0]         col_q, col_d;
  logic [1:0]         row_idx_q, row_idx_d;
  logic [1:0]         col_idx_q, col_idx_d;
  logic [3:0]         key_q, key_d;
  logic               key_valid_q, key_valid_d;
  logic               key_held_q, key_held_d;

  sync_2ff #(
    .WIDTH   (4),
    .RST_VAL (4'b1111)
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row),
    .q     (row_s)
  );

  assign row_info  = row_onehot_idx(row_s);
  assign tick      = (cnt_q == CNT_MAX);
  assign col_rot   = {col_q[2:0], col_q[3]};
  assign match_inc = match_q + MATCH_ONE;

  always_comb begin
    col_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!col_q[i])
        col_idx = 2'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
    match_d     = match_q;
    col_d       = col_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (row_info.cls == ROW_SINGLE) begin
            row_idx_d = row_info.idx;
            col_idx_d = col_idx;
            match_d   = MATCH_ONE;
            state_d   = DEBOUNCE;
          end else begin
            col_d = col_rot;
          end
        end
        DEBOUNCE: begin
          if (row_info.cls == ROW_SINGLE && row_info.idx == row_idx_q) begin
            match_d = match_inc;
            if (match_inc == MATCH_DONE) begin
              key_d       = {row_idx_q, col_idx_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              state_d     = PRESSED;
            end
          end else begin
            match_d = '0;
            col_d   = col_rot;
            state_d = SCAN;
          end
        end
        PRESSED: begin
          if (row_info.cls == ROW_NONE) begin
            match_d = MATCH_ONE;
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (row_info.cls == ROW_NONE) begin
            match_d = match_inc;
            if (match_inc == MATCH_DONE) begin
              match_d    = '0;
              key_held_d = 1'b0;
              col_d      = col_rot;
              state_d    = SCAN;
            end
          end else begin
            // Row activity during release is bounce: resume holding without a new pulse.
            state_d = PRESSED;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      cnt_q       <= '0;
      match_q     <= '0;
      col_q       <= COL_RESET;
      row_idx_q   <= '0;
      col_idx_q   <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      match_q     <= match_d;
      col_q       <= col_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col       = col_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model answers column strobes, a monitor checks every key_valid.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  logic       key_down = 1'b0;
  logic       multi    = 1'b0;
  logic [1:0] kr       = '0;
  logic [1:0] kc       = '0;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  int unsigned pulses    = 0;
  int unsigned ec        = 0;
  logic [3:0]  exp_q[$];

  always #5 clk = ~clk;

  // Keypad model: the held key pulls its row low only while its column is strobed.
  always_comb begin
    row = 4'b1111;
    if (multi)
      row = 4'b1001;
    else if (key_down && col[kc] == 1'b0)
      row = ~(4'b0001 << kr);
  end

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Edges since reset release; every SCAN_DIV-th edge leaves a tick cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ec <= 0;
    else        ec <= ec + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && key_valid === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_valid: key %0h pulsed with no press expected", key);
      end else begin
        check("valid_key", {28'd0, key}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      do begin
        @(posedge clk);
        #1;
      end while (ec % SCAN_DIV != 0);
    end
  endtask

  task automatic wait_held(input logic v, input string name);
    int unsigned n = 0;
    while (key_held !== v && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, {31'd0, key_held}, {31'd0, v});
  endtask

  task automatic wait_col(input logic [3:0] c, input string name);
    int unsigned n = 0;
    while (col !== c && n < 16) begin
      wait_ticks(1);
      n++;
    end
    check(name, {28'd0, col}, {28'd0, c});
  endtask

  initial begin
    int unsigned p;
    logic [3:0]  c;

    repeat (3) @(posedge clk);
    #1;
    check("rst_col",   {28'd0, col}, 32'h0000_000e);
    check("rst_key",   {28'd0, key}, 32'd0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_held",  {31'd0, key_held}, 32'd0);
    #2 rst_n = 1'b1;

    // Press row 1 / col 2 exactly as column 2 is strobed.
    kr = 2'd1; kc = 2'd2;
    wait_col(4'b1011, "s1_reach_col2");
    p = pulses;
    exp_q.push_back(4'b0110);
    key_down = 1'b1;
    wait_ticks(2);
    check("s1_held_early", {31'd0, key_held}, 32'd0);
    wait_ticks(1);
    check("s1_held",    {31'd0, key_held}, 32'd1);
    check("s1_latency", {31'd0, key_valid}, 32'd1);
    wait_ticks(4);
    check("s1_key",    {28'd0, key}, 32'h6);
    check("s1_col",    {28'd0, col}, 32'hb);
    check("s1_pulses", pulses - p, 32'd1);

    // Clean release.
    key_down = 1'b0;
    wait_ticks(2);
    check("s2_held_early", {31'd0, key_held}, 32'd1);
    wait_ticks(1);
    check("s2_held_drop", {31'd0, key_held}, 32'd0);
    check("s2_col",       {28'd0, col}, 32'h7);
    check("s2_key",       {28'd0, key}, 32'h6);

    // Press bounce: alternate down/up each tick, then settle down.
    kr = 2'd2; kc = 2'd1;
    wait_col(4'b1101, "s3_reach_col1");
    p = pulses;
    for (int i = 0; i < 6; i++) begin
      key_down = (i % 2 == 0);
      wait_ticks(1);
    end
    check("s3_no_pulse", pulses - p, 32'd0);
    check("s3_not_held", {31'd0, key_held}, 32'd0);
    exp_q.push_back(4'b1001);
    key_down = 1'b1;
    wait_held(1'b1, "s3_held");
    wait_ticks(1);
    check("s3_key",    {28'd0, key}, 32'h9);
    check("s3_pulses", pulses - p, 32'd1);

    // Release bounce: up, down, then up for good.
    p = pulses;
    key_down = 1'b0;
    wait_ticks(1);
    key_down = 1'b1;
    wait_ticks(1);
    key_down = 1'b0;
    wait_ticks(2);
    check("s4_held_early", {31'd0, key_held}, 32'd1);
    wait_ticks(1);
    check("s4_held_drop", {31'd0, key_held}, 32'd0);
    check("s4_no_pulse",  pulses - p, 32'd0);

    // Two rows low on every column is never a key.
    multi = 1'b1;
    p = pulses;
    c = col;
    for (int i = 0; i < 8; i++) begin
      wait_ticks(1);
      c = {c[2:0], c[3]};
      check("s5_col_rotate", {28'd0, col}, {28'd0, c});
    end
    check("s5_no_pulse", pulses - p, 32'd0);
    check("s5_not_held", {31'd0, key_held}, 32'd0);
    multi = 1'b0;

    // Asynchronous reset while PRESSED, key kept down.
    kr = 2'd3; kc = 2'd0;
    exp_q.push_back(4'b1100);
    key_down = 1'b1;
    wait_held(1'b1, "s6_held");
    wait_ticks(1);
    p = pulses;
    #3 rst_n = 1'b0;
    #1;
    check("s6_rst_col",   {28'd0, col}, 32'he);
    check("s6_rst_key",   {28'd0, key}, 32'd0);
    check("s6_rst_valid", {31'd0, key_valid}, 32'd0);
    check("s6_rst_held",  {31'd0, key_held}, 32'd0);
    exp_q.push_back(4'b1100);
    #6 rst_n = 1'b1;
    wait_held(1'b1, "s6_reheld");
    wait_ticks(2);
    check("s6_key",    {28'd0, key}, 32'hc);
    check("s6_pulses", pulses - p, 32'd1);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
